// File: rtl/tmds_encoder.sv
// rtl/tmds_encoder.sv - one TMDS channel: 8b/10b transition-minimised, DC-balanced encoder
module tmds_encoder (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       de,
    input  logic       c0,
    input  logic       c1,
    output logic [9:0] tmds
);

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [8:0] minimise(input logic [7:0] d);
        logic [3:0] n1d;
        logic       use_xnor;
        logic [8:0] q;
        n1d      = popcount8(d);
        use_xnor = (n1d > 4'd4) || (n1d == 4'd4 && !d[0]);
        q        = 9'd0;
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

    // Stage 1: transition-minimised word plus its ones count
    logic [8:0] q_m_d, q_m_q;
    logic [3:0] n1q_d, n1q_q;
    logic       de_q, c0_q, c1_q;

    assign q_m_d = minimise(data);
    assign n1q_d = popcount8(q_m_d[7:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            q_m_q <= 9'd0;
            n1q_q <= 4'd0;
            de_q  <= 1'b0;
            c0_q  <= 1'b0;
            c1_q  <= 1'b0;
        end else begin
            q_m_q <= q_m_d;
            n1q_q <= n1q_d;
            de_q  <= de;
            c0_q  <= c0;
            c1_q  <= c1;
        end
    end

    // Stage 2: pick inverted or plain payload to steer running disparity toward zero
    logic signed [4:0] cnt_d, cnt_q;
    logic signed [4:0] n1s, n0s, diff;
    logic        [9:0] tmds_d, tmds_q;

    assign n1s  = $signed({1'b0, n1q_q});
    assign n0s  = 5'sd8 - n1s;
    assign diff = n1s - n0s;

    always_comb begin
        tmds_d = tmds_q;
        cnt_d  = cnt_q;
        if (!de_q) begin
            case ({c1_q, c0_q})
                2'b00:   tmds_d = 10'b1101010100;
                2'b01:   tmds_d = 10'b0010101011;
                2'b10:   tmds_d = 10'b0101010100;
                default: tmds_d = 10'b1010101011;
            endcase
            cnt_d = 5'sd0;
        end else if (cnt_q == 5'sd0 || diff == 5'sd0) begin
            tmds_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
            cnt_d  = q_m_q[8] ? (cnt_q + diff) : (cnt_q - diff);
        end else if ((!cnt_q[4] && diff > 5'sd0) || (cnt_q[4] && diff < 5'sd0)) begin
            tmds_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
            cnt_d  = cnt_q + (q_m_q[8] ? 5'sd2 : 5'sd0) - diff;
        end else begin
            tmds_d = {1'b0, q_m_q[8], q_m_q[7:0]};
            cnt_d  = cnt_q - (q_m_q[8] ? 5'sd0 : 5'sd2) + diff;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmds_q <= 10'b1101010100;
            cnt_q  <= 5'sd0;
        end else begin
            tmds_q <= tmds_d;
            cnt_q  <= cnt_d;
        end
    end

    assign tmds = tmds_q;

endmodule

// File: tb/tb_tmds_encoder.sv
// tb/tb_tmds_encoder.sv - scoreboard bench for tmds_encoder with hand-computed vectors
module tb_tmds_encoder;

    localparam logic [9:0] C00 = 10'h354;
    localparam logic [9:0] C01 = 10'h0AB;
    localparam logic [9:0] C10 = 10'h154;
    localparam logic [9:0] C11 = 10'h2AB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'd0;
    logic       de = 1'b0;
    logic       c0 = 1'b0;
    logic       c1 = 1'b0;
    logic [9:0] tmds;

    always #5 clk = ~clk;

    tmds_encoder dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .de   (de),
        .c0   (c0),
        .c1   (c1),
        .tmds (tmds)
    );

    typedef struct {
        int         due;
        logic [9:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    // Monitor: each expected symbol is tagged with the edge after which it must show
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                e = sb.pop_front();
                total++;
                if (e.due != cyc || tmds !== e.exp) begin
                    bad++;
                    $display("FAIL tmds edge=%0d due=%0d got=%h expected=%h", cyc, e.due, tmds, e.exp);
                end
            end
        end
    end

    task automatic drive(input logic r, input logic d, input logic [1:0] c,
                         input logic [7:0] dat, input logic [9:0] exp);
        exp_t e;
        int   edge_n;
        @(negedge clk);
        rst  = r;
        de   = d;
        {c1, c0} = c;
        data = dat;
        edge_n = cyc + 1;
        // Reset on this edge also wipes the symbol that would have emerged from it
        if (r && sb.size() > 0 && sb[sb.size()-1].due == edge_n) begin
            e = sb.pop_back();
            e.exp = C00;
            sb.push_back(e);
        end
        e.due = edge_n + 1;
        e.exp = exp;
        sb.push_back(e);
    endtask

    initial begin
        drive(1, 0, 2'b00, 8'h00, C00);
        drive(1, 0, 2'b00, 8'h00, C00);
        drive(0, 0, 2'b00, 8'h00, C00);
        drive(0, 0, 2'b00, 8'h00, C00);
        drive(0, 0, 2'b01, 8'h00, C01);
        drive(0, 0, 2'b10, 8'h00, C10);
        drive(0, 0, 2'b11, 8'h00, C11);
        drive(0, 0, 2'b00, 8'h00, C00);
        // zeros from cnt=0: -8, +2, -6
        drive(0, 1, 2'b00, 8'h00, 10'h100);
        drive(0, 1, 2'b00, 8'h00, 10'h3FF);
        drive(0, 1, 2'b00, 8'h00, 10'h100);
        drive(0, 0, 2'b00, 8'h00, C00);
        drive(0, 1, 2'b00, 8'hFF, 10'h200);
        drive(0, 0, 2'b00, 8'h00, C00);
        // single video pulse, then a burst restarting from cnt=0
        drive(0, 1, 2'b00, 8'h00, 10'h100);
        drive(0, 0, 2'b10, 8'h00, C10);
        drive(0, 1, 2'b00, 8'h00, 10'h100);
        drive(0, 1, 2'b00, 8'h00, 10'h3FF);
        drive(0, 0, 2'b00, 8'h00, C00);
        // 0x01 -> q_m=0x1FF: cnt 8, 2, -4, 4
        drive(0, 1, 2'b00, 8'h01, 10'h1FF);
        drive(0, 1, 2'b00, 8'h01, 10'h300);
        drive(0, 1, 2'b00, 8'h01, 10'h300);
        drive(0, 1, 2'b00, 8'h01, 10'h1FF);
        drive(0, 0, 2'b00, 8'h00, C00);
        // balanced q_m (0x10 -> 0xF0) keeps cnt at -8
        drive(0, 1, 2'b00, 8'h00, 10'h100);
        drive(0, 1, 2'b00, 8'h10, 10'h1F0);
        drive(0, 1, 2'b00, 8'h00, 10'h3FF);
        drive(0, 0, 2'b00, 8'h00, C00);
        // four-ones tie cases: 0x1E uses XNOR, 0x0F uses XOR
        drive(0, 1, 2'b00, 8'h1E, 10'h25F);
        drive(0, 1, 2'b00, 8'h1E, 10'h0A0);
        drive(0, 1, 2'b00, 8'h0F, 10'h3FA);
        // data ignored while blank, control ignored while active
        drive(0, 0, 2'b00, 8'hFF, C00);
        drive(0, 1, 2'b11, 8'h00, 10'h100);
        drive(0, 0, 2'b11, 8'hA5, C11);
        // reset mid-burst
        drive(0, 1, 2'b00, 8'h00, 10'h100);
        drive(0, 1, 2'b00, 8'h00, 10'h3FF);
        drive(0, 1, 2'b00, 8'h00, 10'h100);
        drive(1, 1, 2'b00, 8'h00, C00);
        drive(0, 1, 2'b00, 8'h00, 10'h100);
        drive(0, 1, 2'b00, 8'h00, 10'h3FF);
        drive(0, 0, 2'b00, 8'h00, C00);

        for (int i = 0; i < 10 && sb.size() > 0; i++) begin
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending symbols, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
